// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, bit-timing helper and break length.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP,
        BREAK
    } state_t;

    localparam int DEFAULT_PAYLOAD_BITS = 8;
    localparam int BREAK_BITS = DEFAULT_PAYLOAD_BITS + 2;

    function automatic int cycles_per_bit(input int clk_hz, input int bit_rate);
        return clk_hz / bit_rate;
    endfunction

    function automatic int break_bits(input int payload_bits);
        return payload_bits + 2;
    endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period cycle counter: counts 0..CYCLES_PER_BIT-1 while run, held at 0 by clear.
// bit_end pulses for one cycle on the last cycle of each bit; no backpressure.
module uart_baud_counter #(
    parameter int CYCLES_PER_BIT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic bit_end
);

    localparam int CW = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CYCLES_PER_BIT - 1);

    logic [CW-1:0] cnt;

    assign bit_end = run && !clear && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= bit_end ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmitter: start, LSB-first data, optional even parity (UART_TX_PARITY_EN), stop; plus BREAK.
// Line and ready change on the accept edge; ready is low for the whole frame, inputs ignored while busy.
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int CLK_HZ       = 100000000,
    parameter int BIT_RATE     = 9600,
    parameter int PAYLOAD_BITS = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    uart_tx_en,
    input  logic [PAYLOAD_BITS-1:0] uart_tx_data,
    input  logic                    uart_tx_valid,
    output logic                    uart_tx_ready,
    input  logic                    uart_tx_break,
    output logic                    uart_txd
);

    localparam int CPB  = cycles_per_bit(CLK_HZ, BIT_RATE);
    localparam int NBRK = break_bits(PAYLOAD_BITS);
    localparam int BCW  = $clog2(PAYLOAD_BITS + 2);

    localparam logic [BCW-1:0] LAST_DATA = BCW'(PAYLOAD_BITS - 1);
    localparam logic [BCW-1:0] LAST_BRK  = BCW'(NBRK - 1);
    localparam logic [BCW-1:0] LAST_STOP = BCW'(STOP_BITS - 1);

    state_t                  state, state_next;
    logic                    txd_q, txd_next;
    logic [PAYLOAD_BITS-1:0] shift_q, shift_next;
    logic [BCW-1:0]          bit_cnt_q, bit_cnt_next;
    logic                    bit_end;

`ifdef UART_TX_PARITY_EN
    logic parity_q, parity_next;
`endif

    assign uart_tx_ready = (state == IDLE) && uart_tx_en;
    assign uart_txd      = txd_q;

    uart_baud_counter #(
        .CYCLES_PER_BIT(CPB)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .clear  (state == IDLE),
        .run    (state != IDLE),
        .bit_end(bit_end)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            txd_q     <= 1'b1;
            shift_q   <= '0;
            bit_cnt_q <= '0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state     <= state_next;
            txd_q     <= txd_next;
            shift_q   <= shift_next;
            bit_cnt_q <= bit_cnt_next;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_next;
`endif
        end
    end

    // txd_next is the level of the state being entered, so the line is registered with no lag.
    always_comb begin
        state_next   = state;
        txd_next     = txd_q;
        shift_next   = shift_q;
        bit_cnt_next = bit_cnt_q;
`ifdef UART_TX_PARITY_EN
        parity_next  = parity_q;
`endif
        case (state)
            IDLE: begin
                txd_next     = 1'b1;
                bit_cnt_next = '0;
                if (uart_tx_en) begin
                    if (uart_tx_break) begin
                        state_next = BREAK;
                        txd_next   = 1'b0;
                    end else if (uart_tx_valid) begin
                        state_next  = START;
                        txd_next    = 1'b0;
                        shift_next  = uart_tx_data;
`ifdef UART_TX_PARITY_EN
                        parity_next = ^uart_tx_data;
`endif
                    end
                end
            end
            START: begin
                if (bit_end) begin
                    state_next   = DATA;
                    txd_next     = shift_q[0];
                    bit_cnt_next = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_next = shift_q >> 1;
                    if (bit_cnt_q == LAST_DATA) begin
`ifdef UART_TX_PARITY_EN
                        state_next = PARITY;
                        txd_next   = parity_q;
`else
                        state_next = STOP;
                        txd_next   = 1'b1;
`endif
                        bit_cnt_next = '0;
                    end else begin
                        bit_cnt_next = bit_cnt_q + BCW'(1);
                        txd_next     = shift_next[0];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_next   = STOP;
                    txd_next     = 1'b1;
                    bit_cnt_next = '0;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    if (bit_cnt_q == LAST_STOP) begin
                        state_next = IDLE;
                        txd_next   = 1'b1;
                    end else begin
                        bit_cnt_next = bit_cnt_q + BCW'(1);
                    end
                end
            end
            BREAK: begin
                if (bit_end) begin
                    if (bit_cnt_q == LAST_BRK) begin
                        // Reuse STOP for the trailing stop bit, preloaded so exactly one bit remains.
                        state_next   = STOP;
                        txd_next     = 1'b1;
                        bit_cnt_next = LAST_STOP;
                    end else begin
                        bit_cnt_next = bit_cnt_q + BCW'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
                txd_next   = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Bench for uart_tx_framer: per-cycle queue model of the line plus directed literal checks.
module tb_uart_tx_framer;

    localparam int CLK_HZ   = 1000;
    localparam int BIT_RATE = 100;
    localparam int PB       = 8;
    localparam int SB       = 1;
    localparam int CPB      = CLK_HZ / BIT_RATE;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FRAME = (1 + PB + PAR + SB) * CPB;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b1;
    logic [PB-1:0] data = '0;
    logic          valid = 1'b0;
    logic          ready;
    logic          brk = 1'b0;
    logic          txd;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    bit line_q[$];
    bit m_txd = 1'b1;
    bit m_busy = 1'b0;

    uart_tx_framer #(
        .CLK_HZ(CLK_HZ), .BIT_RATE(BIT_RATE), .PAYLOAD_BITS(PB), .STOP_BITS(SB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .uart_tx_en   (en),
        .uart_tx_data (data),
        .uart_tx_valid(valid),
        .uart_tx_ready(ready),
        .uart_tx_break(brk),
        .uart_txd     (txd)
    );

    always #5 clk = ~clk;

    task automatic push_bit(input bit v);
        for (int i = 0; i < CPB; i++) line_q.push_back(v);
    endtask

    // Model: a frame is a list of per-cycle line levels, consumed one per edge.
    always @(posedge clk) begin
        if (rst) begin
            line_q.delete();
            m_busy = 1'b0;
            m_txd  = 1'b1;
        end else begin
            if (!m_busy && en && (brk || valid)) begin
                if (brk) begin
                    for (int b = 0; b < PB + 2; b++) push_bit(1'b0);
                    push_bit(1'b1);
                end else begin
                    push_bit(1'b0);
                    for (int b = 0; b < PB; b++) push_bit(data[b]);
                    if (PAR == 1) push_bit(^data);
                    for (int s = 0; s < SB; s++) push_bit(1'b1);
                end
            end
            if (line_q.size() > 0) begin
                m_txd  = line_q.pop_front();
                m_busy = 1'b1;
            end else begin
                m_txd  = 1'b1;
                m_busy = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (cyc > 80000) begin
            $display("FAIL timeout actual=%0d expected<80000", cyc);
            $fatal(1, "bench timeout");
        end
        chk("model_txd", int'(txd), int'(m_txd));
        chk("model_ready", int'(ready), int'(!m_busy && en));
    endtask

    // Accept one request, then sample each bit mid-period until ready returns.
    task automatic run_frame(input logic [PB-1:0] d, input logic v, input logic b,
                             output logic [15:0] bits, output int low, output int zeros);
        data = d; valid = v; brk = b;
        tick();
        valid = 1'b0; brk = 1'b0;
        bits = '0; low = 0; zeros = 0;
        while (!ready && low < 2000) begin
            if (low % CPB == 5) bits[low / CPB] = txd;
            if (!txd) zeros++;
            low++;
            tick();
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!ready && n < 2000) begin
            n++;
            tick();
        end
        chk("wait_idle", int'(ready), 1);
    endtask

    logic [15:0] bits;
    int low, zeros, n;

    initial begin
        // Reset held three cycles while idle.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("reset_txd", int'(txd), 1);
            chk("reset_ready", int'(ready), 1);
        end
        rst = 1'b0;
        tick();

        // Single frame 0xA5.
        run_frame(8'hA5, 1'b1, 1'b0, bits, low, zeros);
        chk("a5_start_data", int'(bits[8:0]), 9'h14A);
        chk("a5_stop", int'(bits[9 + PAR]), 1);
        chk("a5_ready_low", low, (PAR == 1) ? 110 : 100);
        tick();

        // Back-to-back with valid held: 0x00 then 0xFF.
        data = 8'h00; valid = 1'b1;
        tick();
        data = 8'hFF;
        n = 0;
        while (!ready && n < 2000) begin
            n++;
            tick();
        end
        chk("b2b_frame_len", n, FRAME);
        chk("b2b_gap_txd", int'(txd), 1);
        tick();
        chk("b2b_ready_one_cycle", int'(ready), 0);
        chk("b2b_second_start", int'(txd), 0);
        valid = 1'b0;
        repeat (CPB + 5) tick();
        chk("b2b_ff_bit0", int'(txd), 1);
        wait_idle();
        tick();

        // Reset during data bit 3, then a clean 0x3C frame.
        data = 8'h55; valid = 1'b1;
        tick();
        valid = 1'b0;
        repeat (4 * CPB + 3) tick();
        rst = 1'b1;
        tick();
        chk("midrst_txd", int'(txd), 1);
        chk("midrst_ready", int'(ready), 1);
        rst = 1'b0;
        run_frame(8'h3C, 1'b1, 1'b0, bits, low, zeros);
        chk("3c_start_data", int'(bits[8:0]), 9'h078);
        chk("3c_ready_low", low, FRAME);
        tick();

        // Break wins over valid.
        run_frame(8'h81, 1'b1, 1'b1, bits, low, zeros);
        chk("brk_zero_cycles", zeros, 100);
        chk("brk_total", low, 110);
        chk("brk_bits", int'(bits[10:0]), 11'h400);
        tick();

`ifdef UART_TX_PARITY_EN
        run_frame(8'h07, 1'b1, 1'b0, bits, low, zeros);
        chk("par_07", int'(bits[9]), 1);
        chk("par_07_len", low, 110);
        tick();
        run_frame(8'hA5, 1'b1, 1'b0, bits, low, zeros);
        chk("par_a5", int'(bits[9]), 0);
        tick();
`endif

        // Randomized traffic: enable toggling, data churn, occasional break and reset.
        for (int i = 0; i < 4000; i++) begin
            tick();
            en    = ($urandom_range(0, 9) != 0);
            valid = ($urandom_range(0, 3) == 0);
            data  = PB'($urandom);
            brk   = ($urandom_range(0, 199) == 0);
            rst   = ($urandom_range(0, 1499) == 0);
        end
        rst = 1'b0; en = 1'b1; valid = 1'b0; brk = 1'b0;
        tick();
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
